// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the I-cache response path, decode and the fetch queue.
// The queue itself uses the slave view; the surrounding pipeline uses the master view.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush_i;
  logic          issue_i;
  logic          credit_o;
  logic          rsp_valid_i;
  logic [31:0]   rsp_pc_i;
  logic [31:0]   rsp_instr_i;
  logic          deq_valid_o;
  logic          deq_ready_i;
  logic [31:0]   deq_pc_o;
  logic [31:0]   deq_instr_o;
  logic [CW-1:0] count_o;
  logic          err_o;

  modport slave (
    input  flush_i, issue_i, rsp_valid_i, rsp_pc_i, rsp_instr_i, deq_ready_i,
    output credit_o, deq_valid_o, deq_pc_o, deq_instr_o, count_o, err_o
  );

  modport master (
    output flush_i, issue_i, rsp_valid_i, rsp_pc_i, rsp_instr_i, deq_ready_i,
    input  credit_o, deq_valid_o, deq_pc_o, deq_instr_o, count_o, err_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Credit-managed in-order queue of {pc, instr} between the I-cache and decode,
// with stale-response dropping after a redirect and a sticky protocol-error flag.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_queue_if.slave fq
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);

  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [CW-1:0] drop_reg, drop_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic          err_reg, err_next;

  logic [63:0]   mem [DEPTH];
  logic [63:0]   head;

  logic [CW:0]   occupancy;
  logic          credit;
  logic          rsp_live;
  logic          rsp_orphan;
  logic          rsp_fresh;
  logic          full;
  logic          deq_fire;
  logic          enq;
  logic          enq_overflow;

  // Stale requests still hold a slot in inflight but will never land in the queue.
  assign occupancy    = {1'b0, count_reg} + {1'b0, inflight_reg} - {1'b0, drop_reg};
  assign credit       = occupancy < DEPTH_X;

  assign rsp_live     = fq.rsp_valid_i && (inflight_reg != '0);
  assign rsp_orphan   = fq.rsp_valid_i && (inflight_reg == '0);
  assign rsp_fresh    = rsp_live && !fq.flush_i && (drop_reg == '0);
  assign full         = (count_reg == DEPTH_C);
  assign deq_fire     = (count_reg != '0) && !fq.flush_i && fq.deq_ready_i;
  assign enq          = rsp_fresh && (!full || deq_fire);
  assign enq_overflow = rsp_fresh && full && !deq_fire;

  always_comb begin
    count_next    = count_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    inflight_next = inflight_reg;
    drop_next     = drop_reg;
    err_next      = err_reg | rsp_orphan | (fq.issue_i & ~credit) | enq_overflow;

    if (fq.issue_i && !rsp_live && (inflight_reg != DEPTH_C)) begin
      inflight_next = inflight_reg + CW'(1);
    end else if (!fq.issue_i && rsp_live) begin
      inflight_next = inflight_reg - CW'(1);
    end

    if (fq.flush_i) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      // Everything still outstanding before this edge belongs to the old path.
      drop_next   = inflight_reg - CW'(rsp_live);
    end else begin
      if (deq_fire) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      if (enq) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (enq && !deq_fire) begin
        count_next = count_reg + CW'(1);
      end else if (!enq && deq_fire) begin
        count_next = count_reg - CW'(1);
      end
      if (rsp_live && (drop_reg != '0)) begin
        drop_next = drop_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg    <= '0;
      inflight_reg <= '0;
      drop_reg     <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      err_reg      <= 1'b0;
    end else begin
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      err_reg      <= err_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wr_ptr_reg] <= {fq.rsp_pc_i, fq.rsp_instr_i};
    end
  end

  // Storage is never reset, so the head is masked to zero whenever the queue is empty.
  assign head           = mem[rd_ptr_reg];
  assign fq.credit_o    = credit;
  assign fq.deq_valid_o = (count_reg != '0) && !fq.flush_i;
  assign fq.deq_pc_o    = (count_reg != '0) ? head[63:32] : 32'h0;
  assign fq.deq_instr_o = (count_reg != '0) ? head[31:0]  : 32'h0;
  assign fq.count_o     = count_reg;
  assign fq.err_o       = err_reg;
endmodule
